// File: rtl/dpt_pkg.sv
// dpt_pkg: shared types and constants for the double-pulse test sequencer.
//   dpt_state_t  - sequencer state encoding
//   DPT_VOLT_LO  - default DC-bus window lower bound (exclusive)
//   DPT_VOLT_HI  - default DC-bus window upper bound (inclusive)
//   DPT_TW       - width of the shared phase down-counter
//   pairDrive()  - maps the selected pair and its two gate bits onto k_out
package dpt_pkg;

  localparam int          DPT_TW      = 24;
  localparam logic [15:0] DPT_VOLT_LO = 16'h08B0;
  localparam logic [15:0] DPT_VOLT_HI = 16'h0C0C;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    READY,
    PULSE1,
    GAP,
    PULSE2,
    COOL,
    FAULT
  } dpt_state_t;

  // Bit 0 of a pair is the pulsed switch, bit 1 its complementary gate-enable.
  // The pair that is not selected is always driven low.
  function automatic logic [3:0] pairDrive(input logic sel, input logic en,
                                           input logic pulse);
    logic [3:0] drive;
    drive = 4'b0000;
    if (sel) begin
      drive[3:2] = {en, pulse};
    end else begin
      drive[1:0] = {en, pulse};
    end
    return drive;
  endfunction

endpackage

// File: rtl/dpt_fault_sync.sv
// dpt_fault_sync: 2-FF synchronizer for the four asynchronous driver fault pins.
// Resets to 4'hF so that no fault is reported while reset is applied.
//   clk      - system clock
//   rst_n    - asynchronous active-low reset
//   async_i  - raw fault pins, 0 = fault
//   sync_o   - synchronized fault pins, 0 = fault
module dpt_fault_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] async_i,
  output logic [3:0] sync_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  // Two flops in series give the first stage a full cycle to settle before
  // anything downstream looks at the pin state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/dpt_sequencer.sv
// dpt_sequencer: schedules double-pulse gate shots on two switch pairs.
// Arms after ARM_CNT consecutive in-window DC-bus samples, fires one shot per
// trigger (alternating pairs), enforces a cooldown and latches driver faults.
//   clk, sys_rst_n        - clock, asynchronous active-low reset
//   volt, volt_valid      - ADC sample and its one-cycle strobe
//   trig                  - one-cycle debounced trigger
//   fault_n, fault_clr    - async fault pins (0 = fault), fault clear request
//   k_out                 - gate commands, [1:0] pair A, [3:2] pair B
//   ready, busy, done     - armed / shot-or-cooldown / end-of-cooldown pulse
//   trig_miss             - trigger ignored outside READY
//   fault_lat             - latched fault sources, 1 = faulted
module dpt_sequencer
  import dpt_pkg::*;
#(
  parameter logic [DPT_TW-1:0] T_ON1   = 24'd400,
  parameter logic [DPT_TW-1:0] T_GAP   = 24'd100,
  parameter logic [DPT_TW-1:0] T_ON2   = 24'd200,
  parameter logic [DPT_TW-1:0] T_COOL  = 24'd400000,
  parameter logic [7:0]        ARM_CNT = 8'd4,
  parameter logic [15:0]       VOLT_LO = DPT_VOLT_LO,
  parameter logic [15:0]       VOLT_HI = DPT_VOLT_HI
) (
  input  logic        clk,
  input  logic        sys_rst_n,
  input  logic [15:0] volt,
  input  logic        volt_valid,
  input  logic        trig,
  input  logic [3:0]  fault_n,
  input  logic        fault_clr,
  output logic [3:0]  k_out,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic        trig_miss,
  output logic [3:0]  fault_lat
);

  dpt_state_t        state_q, state_d;
  logic [DPT_TW-1:0] cnt_q, cnt_d;
  logic [7:0]        run_q, run_d;
  logic              sel_q, sel_d;
  logic              lastWin_q, lastWin_d;
  logic [3:0]        faultLat_q, faultLat_d;
  logic [3:0]        kOut_q, kOut_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              miss_q, miss_d;

  logic [3:0] faultSync;
  logic       inWin;
  logic       faultAny;
  logic       cntZero;

  dpt_fault_sync u_fault_sync (
    .clk     (clk),
    .rst_n   (sys_rst_n),
    .async_i (fault_n),
    .sync_o  (faultSync)
  );

  assign inWin    = (volt > VOLT_LO) && (volt <= VOLT_HI);
  assign faultAny = ~(&faultSync);
  assign cntZero  = (cnt_q == '0);

  // Next-state logic. Each timed phase loads the shared counter with its
  // length minus one on entry and leaves when it reaches zero, so a phase
  // occupies exactly its programmed number of cycles. The outputs are derived
  // from the next state so that they change on the same edge as the state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    run_d      = run_q;
    sel_d      = sel_q;
    lastWin_d  = volt_valid ? inWin : lastWin_q;
    faultLat_d = faultLat_q;
    done_d     = 1'b0;
    miss_d     = trig && (state_q != READY);

    case (state_q)
      IDLE: begin
        state_d = ARM;
        run_d   = 8'd0;
      end
      ARM: begin
        if (volt_valid) begin
          if (inWin) begin
            run_d = run_q + 8'd1;
            if (run_q + 8'd1 >= ARM_CNT) begin
              state_d = READY;
            end
          end else begin
            run_d = 8'd0;
          end
        end
      end
      READY: begin
        if (trig) begin
          state_d = PULSE1;
          cnt_d   = T_ON1 - 1'b1;
        end else if (volt_valid && !inWin) begin
          state_d = ARM;
          run_d   = 8'd0;
        end
      end
      PULSE1: begin
        if (cntZero) begin
          state_d = GAP;
          cnt_d   = T_GAP - 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cntZero) begin
          state_d = PULSE2;
          cnt_d   = T_ON2 - 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PULSE2: begin
        if (cntZero) begin
          state_d = COOL;
          cnt_d   = T_COOL - 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      COOL: begin
        if (cntZero) begin
          done_d  = 1'b1;
          sel_d   = ~sel_q;
          run_d   = 8'd0;
          // The voltage was ignored during the shot; re-arm from the most
          // recent sample, including one arriving on this very cycle.
          state_d = lastWin_d ? READY : ARM;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FAULT: begin
        if (fault_clr && !faultAny) begin
          state_d    = ARM;
          faultLat_d = 4'b0000;
          sel_d      = 1'b0;
          run_d      = 8'd0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A synchronized fault overrides whatever the case above decided,
    // including a trigger or the end of cooldown on the same cycle.
    if (faultAny && (state_q != IDLE)) begin
      state_d    = FAULT;
      faultLat_d = faultLat_q | ~faultSync;
      done_d     = 1'b0;
      sel_d      = sel_q;
    end

    kOut_d  = pairDrive(sel_d,
                        (state_d == PULSE1) || (state_d == GAP) || (state_d == PULSE2),
                        (state_d == PULSE1) || (state_d == PULSE2));
    ready_d = (state_d == READY);
    busy_d  = (state_d == PULSE1) || (state_d == GAP) ||
              (state_d == PULSE2) || (state_d == COOL);
  end

  // All state and outputs live here; the asynchronous reset drops the gate
  // commands immediately, without waiting for a clock edge.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      run_q      <= 8'd0;
      sel_q      <= 1'b0;
      lastWin_q  <= 1'b0;
      faultLat_q <= 4'b0000;
      kOut_q     <= 4'b0000;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      run_q      <= run_d;
      sel_q      <= sel_d;
      lastWin_q  <= lastWin_d;
      faultLat_q <= faultLat_d;
      kOut_q     <= kOut_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      miss_q     <= miss_d;
    end
  end

  assign k_out     = kOut_q;
  assign ready     = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign trig_miss = miss_q;
  assign fault_lat = faultLat_q;

endmodule
